branch_resolve_unit: RTL and testbench

- Downstream consumer of the branch comparator in the RISC-V EX stage.
- Drives br_un to the comparator and consumes br_less/br_equal with funct3 to resolve conditional branches.
- Owns a 2-bit saturating branch history table (BHT) that supplies fetch-time predictions.
- Raises a registered mispredict/flush pulse with the correct redirect PC.

---
 rtl/bru_pkg.sv | 38 +++
 rtl/bht_2bit.sv | 42 ++++
 rtl/branch_resolve_unit.sv | 135 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolve unit.
// Optional feature macro: BRU_PERF_CNT_EN (performance counters + BHT bypass).
package bru_pkg;

   // Conditional branch funct3 encodings (B-type); 010/011 are not branches.
   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } br_funct3_e;

   // 2-bit saturating branch history counter.
   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t CTR_SNT = 2'b00;
   localparam bht_ctr_t CTR_WNT = 2'b01;
   localparam bht_ctr_t CTR_WT  = 2'b10;
   localparam bht_ctr_t CTR_ST  = 2'b11;

   // Entries start weakly not-taken so the first taken branch flips them.
   localparam bht_ctr_t BHT_RST_VAL = CTR_WNT;

   // Move the counter one step toward the resolved direction, saturating.
   function automatic bht_ctr_t ctr_update(input bht_ctr_t ctr, input logic taken);
      bht_ctr_t res;
      res = ctr;
      if (taken) begin
         if (ctr != CTR_ST) res = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: DEPTH 2-bit saturating counters held in flops.
// Asynchronous read port for fetch, synchronous read-modify-write update
// port for EX, single-cycle parallel synchronous reset.
// With BRU_PERF_CNT_EN defined, a same-index write is forwarded to the read.
module bht_2bit
   import bru_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_ctr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   bht_ctr_t ctr_q [DEPTH];
   bht_ctr_t wr_next;

   assign wr_next = ctr_update(ctr_q[wr_idx], wr_taken);

   // Counter array: parallel clear on reset, otherwise update one entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= BHT_RST_VAL;
      end else if (wr_en) begin
         ctr_q[wr_idx] <= wr_next;
      end
   end

   // Fetch read port; optionally sees the value being written this cycle.
   always_comb begin
      rd_ctr = ctr_q[rd_idx];
`ifdef BRU_PERF_CNT_EN
      if (wr_en && (wr_idx == rd_idx)) rd_ctr = wr_next;
`endif
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: drives the comparator's unsigned select,
// resolves B-type outcomes, trains the BHT and raises a registered one-cycle
// mispredict pulse with the correct redirect PC.
// Optional feature macro: BRU_PERF_CNT_EN adds perf_br_cnt / perf_mis_cnt
// and enables same-cycle write-to-read bypass in the BHT.
//
// Qualification: an EX instruction acts only when ex_valid & ex_is_branch and
// the stage is not stalled; there is no back-pressure, ex_stall simply holds
// all state. During a mispredict pulse the EX slot is wrong-path and ignored.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int BHT_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_stall,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   output logic        br_un,
   input  logic        br_less,
   input  logic        br_equal,
   output logic        ex_taken,
   output logic        mispredict,
   output logic [31:0] redirect_pc
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0] perf_br_cnt,
   output logic [31:0] perf_mis_cnt
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic             resolve_en;
   logic             f3_legal;
   logic             cond_true;
   logic             upd_en;
   logic             mis_set;
   logic [31:0]      fix_pc;
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [1:0]       if_ctr;
   logic             mispredict_q;
   logic [31:0]      redirect_pc_q;
   logic             unused_pc_bits;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];

   // Only part of the fetch PC indexes the table.
   assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

   // funct3[1] separates signed (BLT/BGE) from unsigned (BLTU/BGEU) compares.
   assign br_un = ex_funct3[1];

   // Squashed slots (mispredict pulse) and stalls never resolve.
   assign resolve_en = ex_valid & ex_is_branch & ~ex_stall & ~mispredict_q;

   // Outcome decode from comparator flags; 010/011 are not branches.
   always_comb begin
      f3_legal  = 1'b1;
      cond_true = 1'b0;
      case (ex_funct3)
         F3_BEQ:  cond_true = br_equal;
         F3_BNE:  cond_true = ~br_equal;
         F3_BLT:  cond_true = br_less;
         F3_BGE:  cond_true = ~br_less;
         F3_BLTU: cond_true = br_less;
         F3_BGEU: cond_true = ~br_less;
         default: f3_legal  = 1'b0;
      endcase
   end

   assign upd_en   = resolve_en & f3_legal;
   assign ex_taken = upd_en & cond_true;
   assign mis_set  = upd_en & (ex_taken != ex_pred_taken);
   assign fix_pc   = ex_taken ? ex_target : (ex_pc + 32'd4);

   bht_2bit #(
      .DEPTH (BHT_DEPTH),
      .IDX_W (IDX_W)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (if_idx),
      .rd_ctr   (if_ctr),
      .wr_en    (upd_en),
      .wr_idx   (ex_idx),
      .wr_taken (ex_taken)
   );

   // Prediction is the counter MSB (WT/ST predict taken).
   assign if_pred_taken = if_ctr[1];

   // Flush pulse and redirect register; reset drops any pending redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         mispredict_q  <= 1'b0;
         redirect_pc_q <= 32'h0000_0000;
      end else begin
         mispredict_q <= mis_set;
         if (mis_set) redirect_pc_q <= fix_pc;
      end
   end

   assign mispredict  = mispredict_q;
   assign redirect_pc = redirect_pc_q;

`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_br_q;
   logic [31:0] perf_mis_q;

   // Free-running event counters, wrapping modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_br_q  <= 32'd0;
         perf_mis_q <= 32'd0;
      end else begin
         if (upd_en)  perf_br_q  <= perf_br_q + 32'd1;
         if (mis_set) perf_mis_q <= perf_mis_q + 32'd1;
      end
   end

   assign perf_br_cnt  = perf_br_q;
   assign perf_mis_cnt = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: table-driven decode vectors
// plus directed multi-cycle sequences (training, squash, stall, wrap, reset).
// Perf-counter checks are compiled in when BRU_PERF_CNT_EN is defined.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_stall;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic        br_un;
   logic        br_less;
   logic        br_equal;
   logic        ex_taken;
   logic        mispredict;
   logic [31:0] redirect_pc;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_br_cnt;
   logic [31:0] perf_mis_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [2:0] f3;
      logic       less;
      logic       eq;
      logic       exp_taken;
      logic       exp_un;
   } vec_t;

   vec_t vecs [14];

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   branch_resolve_unit #(.BHT_DEPTH(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .if_pc         (if_pc),
      .if_pred_taken (if_pred_taken),
      .ex_valid      (ex_valid),
      .ex_is_branch  (ex_is_branch),
      .ex_stall      (ex_stall),
      .ex_funct3     (ex_funct3),
      .ex_pc         (ex_pc),
      .ex_target     (ex_target),
      .ex_pred_taken (ex_pred_taken),
      .br_un         (br_un),
      .br_less       (br_less),
      .br_equal      (br_equal),
      .ex_taken      (ex_taken),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc)
`ifdef BRU_PERF_CNT_EN
      ,
      .perf_br_cnt   (perf_br_cnt),
      .perf_mis_cnt  (perf_mis_cnt)
`endif
   );

   // Scoreboard helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_redirect(input string name);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s actual=%h required=<empty queue>", name, redirect_pc);
      end else begin
         e = exp_q.pop_front();
         check(name, redirect_pc, e);
      end
   endtask

   // Driver tasks: inputs change on the falling edge, outputs sampled there too
   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle;
      ex_valid      = 1'b0;
      ex_is_branch  = 1'b0;
      ex_stall      = 1'b0;
      ex_pred_taken = 1'b0;
      br_less       = 1'b0;
      br_equal      = 1'b0;
      #1;
   endtask

   task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic less, input logic eq, input logic stall);
      ex_valid      = 1'b1;
      ex_is_branch  = 1'b1;
      ex_stall      = stall;
      ex_funct3     = f3;
      ex_pc         = pc;
      ex_target     = tgt;
      ex_pred_taken = pred;
      br_less       = less;
      br_equal      = eq;
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      idle();
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{3'b001, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{3'b001, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{3'b100, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{3'b101, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{3'b110, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{3'b111, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{3'b111, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{3'b010, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{3'b011, 1'b1, 1'b1, 1'b0, 1'b1};

      rst       = 1'b1;
      if_pc     = 32'h100;
      ex_funct3 = 3'b000;
      ex_pc     = 32'h0;
      ex_target = 32'h0;
      idle();
      @(negedge clk);
      do_reset();

      // Reset state
      check("rst_pred", {31'd0, if_pred_taken}, 32'd0);
      check("rst_mis", {31'd0, mispredict}, 32'd0);
      check("rst_redir", redirect_pc, 32'h0);

      // BEQ taken, predicted not-taken: flush to target, counter WNT->WT
      drive(3'b000, 32'h100, 32'h140, 1'b0, 1'b0, 1'b1, 1'b0);
      check("beq_taken", {31'd0, ex_taken}, 32'd1);
      check("beq_un", {31'd0, br_un}, 32'd0);
`ifdef BRU_PERF_CNT_EN
      check("bypass_pred", {31'd0, if_pred_taken}, 32'd1);
`else
      check("preupd_pred", {31'd0, if_pred_taken}, 32'd0);
`endif
      exp_q.push_back(32'h140);
      step();
      idle();
      check("beq_mis", {31'd0, mispredict}, 32'd1);
      check_redirect("beq_redir");
      check("beq_trained", {31'd0, if_pred_taken}, 32'd1);
      step();
      check("beq_mis_clr", {31'd0, mispredict}, 32'd0);

      // BLTU not-taken, predicted taken: flush to pc+4; squashed BNE in pulse
      if_pc = 32'h200;
      drive(3'b110, 32'h200, 32'h280, 1'b1, 1'b0, 1'b0, 1'b0);
      check("bltu_un", {31'd0, br_un}, 32'd1);
      check("bltu_taken", {31'd0, ex_taken}, 32'd0);
      exp_q.push_back(32'h204);
      step();
      check("bltu_mis", {31'd0, mispredict}, 32'd1);
      check_redirect("bltu_redir");
      check("bltu_ctr_wnt", {31'd0, if_pred_taken}, 32'd0);
      drive(3'b001, 32'h200, 32'h280, 1'b0, 1'b0, 1'b0, 1'b0);
      check("squash_taken", {31'd0, ex_taken}, 32'd0);
      step();
      idle();
      check("squash_no_mis", {31'd0, mispredict}, 32'd0);
      check("squash_no_upd", {31'd0, if_pred_taken}, 32'd0);
      check("squash_redir_hold", redirect_pc, 32'h204);

      // Table-driven decode, predictions matching so no flush expected
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].f3, 32'h1000 + 32'(4 * i), 32'h3000, vecs[i].exp_taken,
               vecs[i].less, vecs[i].eq, 1'b0);
         check($sformatf("vec%0d_taken", i), {31'd0, ex_taken}, {31'd0, vecs[i].exp_taken});
         check($sformatf("vec%0d_un", i), {31'd0, br_un}, {31'd0, vecs[i].exp_un});
         step();
         check($sformatf("vec%0d_mis", i), {31'd0, mispredict}, 32'd0);
      end
      idle();

      // Saturation: four taken BNE at 0x300, then two not-taken
      do_reset();
      if_pc = 32'h300;
      for (int i = 0; i < 4; i++) begin
         drive(3'b001, 32'h300, 32'h380, 1'b1, 1'b0, 1'b0, 1'b0);
         step();
         check($sformatf("sat%0d_mis", i), {31'd0, mispredict}, 32'd0);
      end
      check("sat_pred", {31'd0, if_pred_taken}, 32'd1);
      drive(3'b001, 32'h300, 32'h380, 1'b1, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(32'h304);
      step();
      idle();
      check("sat_nt_mis", {31'd0, mispredict}, 32'd1);
      check_redirect("sat_nt_redir");
      check("sat_nt_pred_wt", {31'd0, if_pred_taken}, 32'd1);
      step();
      drive(3'b001, 32'h300, 32'h380, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      idle();
      check("sat_nt2_mis", {31'd0, mispredict}, 32'd0);
      check("sat_nt2_pred", {31'd0, if_pred_taken}, 32'd0);

      // Stall holds everything; release resolves and flushes
      do_reset();
      if_pc = 32'h400;
      drive(3'b101, 32'h400, 32'h480, 1'b0, 1'b0, 1'b0, 1'b1);
      check("stall_taken", {31'd0, ex_taken}, 32'd0);
      step();
      check("stall_mis", {31'd0, mispredict}, 32'd0);
      check("stall_pred", {31'd0, if_pred_taken}, 32'd0);
      ex_stall = 1'b0;
      #1;
      check("unstall_taken", {31'd0, ex_taken}, 32'd1);
      exp_q.push_back(32'h480);
      step();
      check("unstall_mis", {31'd0, mispredict}, 32'd1);
      check_redirect("unstall_redir");
      check("unstall_pred", {31'd0, if_pred_taken}, 32'd1);
      idle();
      ex_stall = 1'b1;
      step();
      check("stall_selfclr", {31'd0, mispredict}, 32'd0);
      drive(3'b010, 32'h400, 32'h480, 1'b1, 1'b1, 1'b1, 1'b0);
      check("f3_010_taken", {31'd0, ex_taken}, 32'd0);
      step();
      idle();
      check("f3_010_mis", {31'd0, mispredict}, 32'd0);
      check("f3_010_no_upd", {31'd0, if_pred_taken}, 32'd1);

      // pc+4 wraps at the top of the address space
      drive(3'b000, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'h0);
      step();
      idle();
      check("wrap_mis", {31'd0, mispredict}, 32'd1);
      check_redirect("wrap_redir");
      step();

      // Reset coinciding with a mispredicting branch discards the redirect
      if_pc = 32'h500;
      drive(3'b000, 32'h500, 32'h600, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      check("rstmid_mis", {31'd0, mispredict}, 32'd0);
      check("rstmid_redir", redirect_pc, 32'h0);
      check("rstmid_bht", {31'd0, if_pred_taken}, 32'd0);

`ifdef BRU_PERF_CNT_EN
      // Ten branches, the first three mispredicted
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(3'b000, 32'h2000 + 32'(4 * i), 32'h2800, (i >= 3), 1'b0, 1'b1, 1'b0);
         step();
         if (mispredict) begin
            idle();
            step();
         end
      end
      idle();
      step();
      check("perf_br", perf_br_cnt, 32'd10);
      check("perf_mis", perf_mis_cnt, 32'd3);
      drive(3'b000, 32'h2100, 32'h2800, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      check("perf_rst_br", perf_br_cnt, 32'd0);
      check("perf_rst_mis", perf_mis_cnt, 32'd0);
      check("perf_rst_pulse", {31'd0, mispredict}, 32'd0);
`endif

      // Final report
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
